bus_coherence_ctrl: RTL and testbench
=====================================

BUS_COHERENCE_CTRL -- requirements
Module: bus_coherence_ctrl

Interface
REQ-001 SHALL have parameter CPUS, default 4, number of cache ports (2..8).
REQ-002 SHALL have parameter WORD_W, default 32, data and address width.
REQ-003 SHALL have parameter BLK_WORDS, default 2, words per coherent block transfer (1..4).
REQ-004 SHALL have port CLK  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port nRST  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports iREN, dREN, dWEN, cctrans, ccwrite  in  CPUS  per-cache requests; bit n belongs to cache n.
REQ-007 SHALL have ports iaddr, daddr, dstore  in  CPUS*WORD_W  per-cache address/data; slice n is [n*WORD_W +: WORD_W].
REQ-008 SHALL have ports iwait, dwait  out  CPUS  per-cache stall, 1 = wait.
REQ-009 SHALL have ports iload, dload  out  CPUS*WORD_W  per-cache read data.
REQ-010 SHALL have ports ccwait, ccinv  out  CPUS  snoop stall / invalidate to cache n.
REQ-011 SHALL have port ccsnoopaddr  out  CPUS*WORD_W  snoop address to cache n.
REQ-012 SHALL have ports ramREN, ramWEN  out  1, ramaddr, ramstore  out  WORD_W  RAM request.
REQ-013 SHALL have ports ramload  in  WORD_W, ramstate  in  2  RAM data/status; ACCESS = 2'b10.

Function
REQ-014 SHALL implement states IDLE, SNOOP, C2C, MEMRD, UPGR, WB, IFETCH; one transaction in flight.
REQ-015 IDLE priority: coherent request (cctrans) > writeback (dWEN without cctrans) > instruction fetch (iREN).
REQ-016 Each class SHALL arbitrate round-robin: search starts at (last grant of that class + 1) mod CPUS; grant id latched on leaving IDLE.
REQ-017 Coherent grant r: IDLE -> SNOOP; in SNOOP, ccwait[k]=1 and ccsnoopaddr[k]=daddr[r] for all k != r; ccinv[k]=ccwrite[r].
REQ-018 SNOOP SHALL last exactly one cycle, then sample ccwrite of snoopers: lowest-index k != r with ccwrite[k]=1 is responder s.
REQ-019 SNOOP exit: responder present -> C2C; else dREN[r] -> MEMRD; else -> UPGR.
REQ-020 C2C: dload[r]=dstore[s]; ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s]; on ramstate==ACCESS, dwait[r]=dwait[s]=0 same cycle.
REQ-021 MEMRD: ramREN=1, ramaddr=daddr[r], dload[r]=ramload; on ACCESS dwait[r]=0.
REQ-022 C2C and MEMRD SHALL count BLK_WORDS ACCESS beats (2-bit beat counter, cleared on entry); last beat -> IDLE.
REQ-023 UPGR: hold snoop outputs; exit to IDLE when cctrans[r]=0; no RAM access.
REQ-024 Through SNOOP/C2C/MEMRD/UPGR, ccwait, ccsnoopaddr, ccinv to all k != r SHALL remain driven as in REQ-017.
REQ-025 WB: ramWEN=1, address/data of granted cache; dwait=0 on ACCESS; -> IDLE after that beat.
REQ-026 IFETCH: ramREN=1, ramaddr=iaddr[g], iload[g]=ramload; iwait[g]=0 on ACCESS; -> IDLE that beat.
REQ-027 Round-robin pointer of a class SHALL update to the grant id when its transaction completes.
REQ-028 Defaults, all states: iwait=dwait='1, ccwait=ccinv='0, ccsnoopaddr='0, ramREN=ramWEN=0, ramaddr=ramstore='0; iload/dload slices = ramload unless REQ-020 overrides.
REQ-029 Never assert ramREN and ramWEN together; ramaddr always from the granted cache only.
REQ-030 ramstate ERROR or BUSY SHALL hold current state; no beat counted.
REQ-031 Requester dropping cctrans mid C2C/MEMRD SHALL not abort; transfer completes.

Reset
REQ-032 nRST=0 at a rising edge: state=IDLE, beat counter=0, all round-robin pointers=CPUS-1 (first search starts at cache 0).
REQ-033 Reset mid-transaction SHALL abandon it; outputs take REQ-028 defaults from the cycle after the edge.

Verification
REQ-034 CPUS=4: cctrans[1], ccwrite[1]=0, dREN[1]=1, no snoop response, RAM ACCESS each cycle -> SNOOP 1 cycle, ccwait=4'b1101, then 2 ramREN beats, dwait[1]=0 twice, IDLE.
REQ-035 cctrans[0] read, cache 2 ccwrite=1 with dstore=0xDEADBEEF -> dload[0]=0xDEADBEEF, ramWEN=1 ramaddr=daddr[2], dwait[0]=dwait[2]=0 per beat.
REQ-036 All four cctrans held high -> grants in order 0,1,2,3,0; no cache granted twice before others.
REQ-037 cctrans[3], ccwrite[3]=1, dREN[3]=0 -> ccinv=4'b0111 until cctrans[3] falls, ramREN=ramWEN=0 throughout.
REQ-038 dWEN[2] and iREN[0] together, ramstate BUSY 3 cycles then ACCESS -> writeback first (dwait[2]=0 cycle 4), then IFETCH cache 0.
REQ-039 nRST low during MEMRD beat 1 -> next cycle IDLE, all waits 1, ram controls 0; post-reset first grant to cache 0.

Source files
------------

// File: rtl/bus_coherence_ctrl.sv
// rtl/bus_coherence_ctrl.sv - snooping bus coherence controller arbitrating CPUS caches onto one RAM port
module bus_coherence_ctrl #(
   parameter int CPUS      = 4,
   parameter int WORD_W    = 32,
   parameter int BLK_WORDS = 2
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic [CPUS-1:0]          iREN,
   input  logic [CPUS-1:0]          dREN,
   input  logic [CPUS-1:0]          dWEN,
   input  logic [CPUS-1:0]          cctrans,
   input  logic [CPUS-1:0]          ccwrite,
   input  logic [CPUS*WORD_W-1:0]   iaddr,
   input  logic [CPUS*WORD_W-1:0]   daddr,
   input  logic [CPUS*WORD_W-1:0]   dstore,
   output logic [CPUS-1:0]          iwait,
   output logic [CPUS-1:0]          dwait,
   output logic [CPUS*WORD_W-1:0]   iload,
   output logic [CPUS*WORD_W-1:0]   dload,
   output logic [CPUS-1:0]          ccwait,
   output logic [CPUS-1:0]          ccinv,
   output logic [CPUS*WORD_W-1:0]   ccsnoopaddr,
   output logic                     ramREN,
   output logic                     ramWEN,
   output logic [WORD_W-1:0]        ramaddr,
   output logic [WORD_W-1:0]        ramstore,
   input  logic [WORD_W-1:0]        ramload,
   input  logic [1:0]               ramstate
);
   localparam int               IDW       = (CPUS > 1) ? $clog2(CPUS) : 1;
   localparam logic [1:0]       ACCESS    = 2'b10;
   localparam logic [1:0]       LAST_BEAT = 2'(BLK_WORDS - 1);
   localparam logic [IDW-1:0]   PTR_RST   = IDW'(CPUS - 1);

   typedef enum logic [2:0] {IDLE, SNOOP, C2C, MEMRD, UPGR, WB, IFETCH} state_t;

   state_t           state, next_state;
   logic [IDW-1:0]   gnt, resp, rr_cc, rr_wb, rr_if;
   logic [1:0]       beat;
   logic [IDW:0]     pick_cc, pick_wb, pick_if, snoop_hit;   // {found, id}
   logic             access, done, beat_inc;
   logic [WORD_W-1:0] g_daddr, g_dstore, g_iaddr, s_daddr, s_dstore;

   // round-robin search starting one past the last grant of the class
   function automatic logic [IDW:0] rr_pick(input logic [CPUS-1:0] req, input logic [IDW-1:0] ptr);
      logic [IDW:0]   res;
      logic [IDW-1:0] idx;
      res = '0;
      for (int i = 1; i <= CPUS; i++) begin
         idx = IDW'((int'(ptr) + i) % CPUS);
         if (req[idx] && !res[IDW]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign access  = (ramstate == ACCESS);
   assign pick_cc = rr_pick(cctrans, rr_cc);
   assign pick_wb = rr_pick(dWEN & ~cctrans, rr_wb);
   assign pick_if = rr_pick(iREN, rr_if);

   assign g_daddr  = daddr[int'(gnt)*WORD_W +: WORD_W];
   assign g_dstore = dstore[int'(gnt)*WORD_W +: WORD_W];
   assign g_iaddr  = iaddr[int'(gnt)*WORD_W +: WORD_W];
   assign s_daddr  = daddr[int'(resp)*WORD_W +: WORD_W];
   assign s_dstore = dstore[int'(resp)*WORD_W +: WORD_W];

   // lowest-index snooper (not the requester) claiming a dirty copy
   always_comb begin
      snoop_hit = '0;
      for (int k = CPUS - 1; k >= 0; k--)
         if (ccwrite[k] && (IDW'(k) != gnt)) snoop_hit = {1'b1, IDW'(k)};
   end

   // state register
   always_ff @(posedge CLK) begin
      if (!nRST) state <= IDLE;
      else       state <= next_state;
   end

   // grant, responder, beat counter and round-robin pointers
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         gnt   <= '0;
         resp  <= '0;
         beat  <= '0;
         rr_cc <= PTR_RST;
         rr_wb <= PTR_RST;
         rr_if <= PTR_RST;
      end else begin
         if (state == IDLE) begin
            beat <= '0;
            if (pick_cc[IDW])      gnt <= pick_cc[IDW-1:0];
            else if (pick_wb[IDW]) gnt <= pick_wb[IDW-1:0];
            else if (pick_if[IDW]) gnt <= pick_if[IDW-1:0];
         end
         if (state == SNOOP) begin
            resp <= snoop_hit[IDW-1:0];
            beat <= '0;
         end
         if (beat_inc) beat <= beat + 2'd1;
         if (done) begin
            case (state)
               C2C, MEMRD, UPGR: rr_cc <= gnt;
               WB:               rr_wb <= gnt;
               IFETCH:           rr_if <= gnt;
               default:          ;
            endcase
         end
      end
   end

   // next-state and output decode
   always_comb begin
      next_state  = state;
      done        = 1'b0;
      beat_inc    = 1'b0;
      iwait       = '1;
      dwait       = '1;
      ccwait      = '0;
      ccinv       = '0;
      ccsnoopaddr = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      iload       = {CPUS{ramload}};
      dload       = {CPUS{ramload}};

      // snoopers stay stalled and see the requester's address for the whole coherent transaction
      if (state inside {SNOOP, C2C, MEMRD, UPGR}) begin
         for (int k = 0; k < CPUS; k++) begin
            if (IDW'(k) != gnt) begin
               ccwait[k] = 1'b1;
               ccinv[k]  = ccwrite[gnt];
               ccsnoopaddr[k*WORD_W +: WORD_W] = g_daddr;
            end
         end
      end

      case (state)
         IDLE: begin
            if (pick_cc[IDW])      next_state = SNOOP;
            else if (pick_wb[IDW]) next_state = WB;
            else if (pick_if[IDW]) next_state = IFETCH;
         end
         SNOOP: begin
            if (snoop_hit[IDW]) next_state = C2C;
            else if (dREN[gnt]) next_state = MEMRD;
            else                next_state = UPGR;
         end
         C2C: begin
            // dirty data goes to the requester and is written back to RAM in the same beat
            ramWEN   = 1'b1;
            ramaddr  = s_daddr;
            ramstore = s_dstore;
            dload[int'(gnt)*WORD_W +: WORD_W] = s_dstore;
            if (access) begin
               dwait[gnt]  = 1'b0;
               dwait[resp] = 1'b0;
               beat_inc    = 1'b1;
               if (beat == LAST_BEAT) begin
                  done       = 1'b1;
                  next_state = IDLE;
               end
            end
         end
         MEMRD: begin
            ramREN  = 1'b1;
            ramaddr = g_daddr;
            if (access) begin
               dwait[gnt] = 1'b0;
               beat_inc   = 1'b1;
               if (beat == LAST_BEAT) begin
                  done       = 1'b1;
                  next_state = IDLE;
               end
            end
         end
         UPGR: begin
            if (!cctrans[gnt]) begin
               done       = 1'b1;
               next_state = IDLE;
            end
         end
         WB: begin
            ramWEN   = 1'b1;
            ramaddr  = g_daddr;
            ramstore = g_dstore;
            if (access) begin
               dwait[gnt] = 1'b0;
               done       = 1'b1;
               next_state = IDLE;
            end
         end
         IFETCH: begin
            ramREN  = 1'b1;
            ramaddr = g_iaddr;
            if (access) begin
               iwait[gnt] = 1'b0;
               done       = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end
endmodule

// File: tb/tb_bus_coherence_ctrl.sv
// tb/tb_bus_coherence_ctrl.sv - scoreboard bench for bus_coherence_ctrl with CPUS=4, BLK_WORDS=2
module tb_bus_coherence_ctrl;
   localparam logic [1:0]  ACC   = 2'b10;
   localparam logic [1:0]  BUSY  = 2'b01;
   localparam logic [1:0]  ERR   = 2'b11;
   localparam logic [31:0] RAMLD = 32'h5A5A_0F0F;

   logic         CLK, nRST;
   logic [3:0]   iREN, dREN, dWEN, cctrans, ccwrite;
   logic [127:0] iaddr, daddr, dstore;
   logic [3:0]   iwait, dwait, ccwait, ccinv;
   logic [127:0] iload, dload, ccsnoopaddr;
   logic         ramREN, ramWEN;
   logic [31:0]  ramaddr, ramstore, ramload;
   logic [1:0]   ramstate;

   typedef struct {
      string        tag;
      logic [3:0]   dw, iw, cw, ci;
      logic         ren, wen;
      logic [31:0]  addr, store;
      logic [127:0] snp;
      int           dsel, port;
      logic [31:0]  dval;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   order[5] = '{0, 1, 2, 3, 0};
   int   g;

   bus_coherence_ctrl #(.CPUS(4), .WORD_W(32), .BLK_WORDS(2)) dut (
      .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
      .cctrans(cctrans), .ccwrite(ccwrite), .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] da(input int n);
      return daddr[n*32 +: 32];
   endfunction

   function automatic logic [31:0] ia(input int n);
      return iaddr[n*32 +: 32];
   endfunction

   function automatic logic [31:0] st(input int n);
      return dstore[n*32 +: 32];
   endfunction

   function automatic logic [127:0] snp_of(input int gg);
      logic [127:0] v;
      v = '0;
      if (gg >= 0)
         for (int k = 0; k < 4; k++)
            if (k != gg) v[k*32 +: 32] = da(gg);
      return v;
   endfunction

   task automatic push(input string tag, input logic [3:0] dw, iw, cw, ci, input logic ren, wen,
                       input logic [31:0] addr, store, input int sg, dsel, port, input logic [31:0] dval);
      exp_t e;
      e.tag = tag; e.dw = dw; e.iw = iw; e.cw = cw; e.ci = ci;
      e.ren = ren; e.wen = wen; e.addr = addr; e.store = store;
      e.snp = snp_of(sg); e.dsel = dsel; e.port = port; e.dval = dval;
      sb.push_back(e);
   endtask

   task automatic push_idle(input string tag);
      push(tag, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, -1, 0, 0, 32'h0);
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // compare queued expectations at the falling edge, then move to just after the next rising edge
   task automatic cyc();
      exp_t e;
      @(negedge CLK);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk({e.tag, ".dwait"},  dwait,  e.dw);
         chk({e.tag, ".iwait"},  iwait,  e.iw);
         chk({e.tag, ".ccwait"}, ccwait, e.cw);
         chk({e.tag, ".ccinv"},  ccinv,  e.ci);
         chk({e.tag, ".ramREN"}, ramREN, e.ren);
         chk({e.tag, ".ramWEN"}, ramWEN, e.wen);
         chk({e.tag, ".ramaddr"},  ramaddr,  e.addr);
         chk({e.tag, ".ramstore"}, ramstore, e.store);
         chk({e.tag, ".snoopaddr"}, ccsnoopaddr, e.snp);
         if (e.dsel == 1)      chk({e.tag, ".dload"}, dload[e.port*32 +: 32], e.dval);
         else if (e.dsel == 2) chk({e.tag, ".iload"}, iload[e.port*32 +: 32], e.dval);
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
      ramstate = ACC; ramload = RAMLD;
      for (int n = 0; n < 4; n++) begin
         iaddr[n*32 +: 32]  = 32'h0000_1000 + 32'(n * 4);
         daddr[n*32 +: 32]  = 32'h2000_0000 + 32'(n * 'h100);
         dstore[n*32 +: 32] = 32'hA000_0000 + 32'(n);
      end
      @(posedge CLK); #1;
      push_idle("reset"); cyc();
      nRST = 1'b1;

      // coherent read of cache 1 with no responder: memory read of two beats, one error cycle between
      cctrans = 4'b0010; dREN = 4'b0010;
      push_idle("t1_idle"); cyc();
      push("t1_snoop", 4'hF, 4'hF, 4'b1101, 4'b0000, 0, 0, 0, 0, 1, 0, 0, 0); cyc();
      push("t1_beat0", 4'b1101, 4'hF, 4'b1101, 4'b0000, 1, 0, da(1), 0, 1, 1, 1, RAMLD); cyc();
      ramstate = ERR;
      push("t1_error", 4'hF, 4'hF, 4'b1101, 4'b0000, 1, 0, da(1), 0, 1, 0, 0, 0); cyc();
      ramstate = ACC; cctrans = '0; dREN = '0;
      push("t1_beat1", 4'b1101, 4'hF, 4'b1101, 4'b0000, 1, 0, da(1), 0, 1, 1, 1, RAMLD); cyc();
      push_idle("t1_done"); cyc();

      // cache 0 reads, cache 2 supplies dirty data
      dstore[2*32 +: 32] = 32'hDEAD_BEEF;
      cctrans = 4'b0001; dREN = 4'b0001; ccwrite = 4'b0100;
      push_idle("t2_idle"); cyc();
      push("t2_snoop", 4'hF, 4'hF, 4'b1110, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
      push("t2_beat0", 4'b1010, 4'hF, 4'b1110, 4'b0000, 0, 1, da(2), 32'hDEAD_BEEF, 0, 1, 0, 32'hDEAD_BEEF); cyc();
      cctrans = '0; dREN = '0;
      push("t2_beat1", 4'b1010, 4'hF, 4'b1110, 4'b0000, 0, 1, da(2), 32'hDEAD_BEEF, 0, 1, 0, 32'hDEAD_BEEF); cyc();
      push_idle("t2_done"); cyc();
      ccwrite = '0;

      // upgrade by cache 3: invalidate others until cctrans drops, no RAM traffic
      cctrans = 4'b1000; ccwrite = 4'b1000;
      push_idle("t3_idle"); cyc();
      push("t3_snoop", 4'hF, 4'hF, 4'b0111, 4'b0111, 0, 0, 0, 0, 3, 0, 0, 0); cyc();
      push("t3_upgr0", 4'hF, 4'hF, 4'b0111, 4'b0111, 0, 0, 0, 0, 3, 0, 0, 0); cyc();
      cctrans = '0;
      push("t3_upgr1", 4'hF, 4'hF, 4'b0111, 4'b0111, 0, 0, 0, 0, 3, 0, 0, 0); cyc();
      push_idle("t3_done"); cyc();
      ccwrite = '0;

      // writeback beats instruction fetch; RAM busy three cycles
      dWEN = 4'b0100; iREN = 4'b0001; ramstate = BUSY;
      push_idle("t4_idle"); cyc();
      for (int i = 0; i < 3; i++) begin
         push("t4_busy", 4'hF, 4'hF, 4'h0, 4'h0, 0, 1, da(2), st(2), -1, 0, 0, 0); cyc();
      end
      ramstate = ACC; dWEN = '0;
      push("t4_wb", 4'b1011, 4'hF, 4'h0, 4'h0, 0, 1, da(2), st(2), -1, 0, 0, 0); cyc();
      push_idle("t4_gap"); cyc();
      iREN = '0;
      push("t4_ifetch", 4'hF, 4'b1110, 4'h0, 4'h0, 1, 0, ia(0), 0, -1, 2, 0, RAMLD); cyc();
      push_idle("t4_done"); cyc();

      // all caches request coherent reads: grants rotate 0,1,2,3,0
      cctrans = 4'hF; dREN = 4'hF;
      for (int j = 0; j < 5; j++) begin
         g = order[j];
         push_idle("t5_idle"); cyc();
         push("t5_snoop", 4'hF, 4'hF, ~(4'b1 << g), 4'h0, 0, 0, 0, 0, g, 0, 0, 0); cyc();
         push("t5_beat0", ~(4'b1 << g), 4'hF, ~(4'b1 << g), 4'h0, 1, 0, da(g), 0, g, 1, g, RAMLD); cyc();
         if (j == 4) begin cctrans = '0; dREN = '0; end
         push("t5_beat1", ~(4'b1 << g), 4'hF, ~(4'b1 << g), 4'h0, 1, 0, da(g), 0, g, 1, g, RAMLD); cyc();
      end
      push_idle("t5_done"); cyc();

      // reset during a memory read, then the first grant goes to cache 0
      cctrans = 4'b0010; dREN = 4'b0010;
      push_idle("t6_idle"); cyc();
      push("t6_snoop", 4'hF, 4'hF, 4'b1101, 4'h0, 0, 0, 0, 0, 1, 0, 0, 0); cyc();
      nRST = 1'b0; cctrans = '0; dREN = '0;
      push("t6_beat0", 4'b1101, 4'hF, 4'b1101, 4'h0, 1, 0, da(1), 0, 1, 1, 1, RAMLD); cyc();
      nRST = 1'b1; cctrans = 4'hF; dREN = 4'hF;
      push_idle("t6_after_rst"); cyc();
      push("t6_snoop0", 4'hF, 4'hF, 4'b1110, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
      push("t6_rd0", 4'b1110, 4'hF, 4'b1110, 4'h0, 1, 0, da(0), 0, 0, 1, 0, RAMLD); cyc();
      cctrans = '0; dREN = '0;
      push("t6_rd1", 4'b1110, 4'hF, 4'b1110, 4'h0, 1, 0, da(0), 0, 0, 1, 0, RAMLD); cyc();
      push_idle("t6_done"); cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
